dff_response_checker: RTL
=========================

# dff_response_checker

Synthesizable response checker for the D flip-flop with active-low asynchronous preset/clear. It is the observing end of the flip-flop stimulus interface: it samples the same D/PRE_B/CLR_B that drive the flip-flop under test, plus its Q/Qb, on the shared clock. It runs a cycle-level golden model and reports mismatches, forbidden preset+clear events and the index of the first failure. It sits beside the flip-flop in lab and regression setups, so pass/fail is read from counters instead of waveforms.

## Interface
Parameters:
- CNT_W, 8, width of the saturating error and forbidden-event counters
- IDX_W, 16, width of the sample index and first-error index
- STOP_ON_ERR, 0, 1 = enter HALT on the first mismatch

Ports:
- Clk  in  1  checker clock, same clock as the flip-flop under test; rising edge
- CLR_B  in  1  checker reset, asynchronous, active-low
- en  in  1  check enable
- D_obs  in  1  observed D input of the flip-flop
- PRE_B_obs  in  1  observed preset, active-low
- CLR_B_obs  in  1  observed clear, active-low
- Q_obs  in  1  observed Q
- Qb_obs  in  1  observed Qb
- err  out  1  registered one-cycle mismatch pulse
- err_cnt  out  CNT_W  mismatch count, saturating
- forb_cnt  out  CNT_W  count of PRE_B_obs = CLR_B_obs = 0 samples, saturating
- sample_idx  out  IDX_W  number of compared samples, saturating
- first_err_idx  out  IDX_W  sample_idx value at the first mismatch
- first_err_vld  out  1  first_err_idx is valid
- halted  out  1  checker is in HALT

## Operation
- Reset (CLR_B = 0, asynchronous):
  - state = WARMUP
  - exp_q = 0, exp_vld = 0
  - all outputs 0
- States:
  - WARMUP: first enabled edge loads the expectation; no compare. Next state RUN.
  - RUN: compare, then update the expectation.
  - HALT: every register frozen. Exit only via reset.
- Next expectation at each enabled edge (clear has priority):
  - CLR_B_obs = 0: exp_q = 0
  - else PRE_B_obs = 0: exp_q = 1
  - else: exp_q = D_obs
  - exp_vld = 1
- Forbidden sample: PRE_B_obs = 0 and CLR_B_obs = 0.
  - forb_cnt increments.
  - exp_vld is cleared, so the next edge is not compared.
  - No compare at this edge.
- Expected value now (asynchronous level override at the current edge):
  - only CLR_B_obs low: 0
  - only PRE_B_obs low: 1
  - otherwise: exp_q
- Mismatch, checked in RUN with exp_vld = 1 and the sample not forbidden:
  - Q_obs differs from the expected value now, or
  - Qb_obs differs from the inverse of Q_obs.
- On each compared edge:
  - sample_idx increments (saturating).
  - On mismatch: err = 1 next cycle and err_cnt increments.
  - If first_err_vld = 0: first_err_idx captures the pre-increment sample_idx and first_err_vld is set.
  - If STOP_ON_ERR = 1: go to HALT and set halted.
- en = 0 at an edge:
  - Counters hold.
  - exp_vld cleared.
  - RUN returns to WARMUP. HALT stays in HALT.
- Saturation: err_cnt and forb_cnt hold at 2^CNT_W - 1; sample_idx holds at 2^IDX_W - 1.

## Timing
- All outputs are registered and update on the Clk rising edge where the event is sampled.
- Sample-to-flag latency is 0 cycles. err is high for exactly one cycle per mismatching edge; back-to-back mismatches keep err high on consecutive cycles.
- Observed inputs must meet setup/hold at Clk. Asynchronous preset/clear pulses that do not span an edge are invisible to the checker by definition.
- Reset deasserted mid-run: the checker restarts in WARMUP; the first edge after reset never flags.

## Structure
- Package dff_chk_pkg holds:
  - state enum: WARMUP, RUN, HALT
  - function exp_next(d, pre_b, clr_b), clear-priority resolution
  - function exp_now(exp_q, pre_b, clr_b)
- Sub-module dff_golden_model: exp_q/exp_vld register plus forbidden detection. Top level holds the FSM and the counters.

## Test plan
- Reset, en = 1, D_obs toggles 1,0,1,1 with a correct Q/Qb trace -> err never 1; err_cnt = 0; sample_idx = 3 after 4 edges.
- CLR_B_obs = 0 held for 3 edges with Q_obs = 0, then released with D_obs = 1 -> no error; next compared Q_obs must be 1.
- PRE_B_obs = 0 while D_obs = 0 and Q_obs = 0 -> err pulse one cycle; err_cnt = 1; first_err_vld = 1; first_err_idx = current sample_idx.
- PRE_B_obs = CLR_B_obs = 0 for one edge with Q_obs = Qb_obs = 1 -> forb_cnt = 1; no err at that edge or the next edge.
- STOP_ON_ERR = 1 with Qb_obs stuck at 1 while Q_obs = 1 -> halted = 1 after the first mismatch; err_cnt stays 1 across 10 more edges; reset returns all outputs to 0.
- CNT_W = 2 with a constant mismatch for 6 edges -> err_cnt saturates at 3; err stays high on every edge.

Source files
------------

// File: rtl/dff_chk_pkg.sv
// Shared types and golden-model helpers for the D flip-flop response checker.
package dff_chk_pkg;

    typedef enum logic [1:0] {
        WARMUP = 2'd0,
        RUN    = 2'd1,
        HALT   = 2'd2
    } chk_state_e;

    // One observed sample of the flip-flop pins
    typedef struct packed {
        logic d;
        logic pre_b;
        logic clr_b;
        logic q;
        logic qb;
    } obs_t;

    // Value the flip-flop should hold after this edge; clear wins over preset
    function automatic logic exp_next(input logic d, input logic pre_b, input logic clr_b);
        if (!clr_b) begin
            return 1'b0;
        end else if (!pre_b) begin
            return 1'b1;
        end
        return d;
    endfunction

    // Value Q should show at this edge, including an active asynchronous override
    function automatic logic exp_now(input logic exp_q, input logic pre_b, input logic clr_b);
        if (!clr_b && pre_b) begin
            return 1'b0;
        end else if (clr_b && !pre_b) begin
            return 1'b1;
        end
        return exp_q;
    endfunction

endpackage

// File: rtl/dff_response_checker_if.sv
// Observation bus between the flip-flop under test and its response checker.
interface dff_response_checker_if #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned IDX_W = 16
);
    logic             en;
    logic             D_obs;
    logic             PRE_B_obs;
    logic             CLR_B_obs;
    logic             Q_obs;
    logic             Qb_obs;
    logic             err;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] forb_cnt;
    logic [IDX_W-1:0] sample_idx;
    logic [IDX_W-1:0] first_err_idx;
    logic             first_err_vld;
    logic             halted;

    modport master (
        output en, D_obs, PRE_B_obs, CLR_B_obs, Q_obs, Qb_obs,
        input  err, err_cnt, forb_cnt, sample_idx, first_err_idx, first_err_vld, halted
    );

    modport slave (
        input  en, D_obs, PRE_B_obs, CLR_B_obs, Q_obs, Qb_obs,
        output err, err_cnt, forb_cnt, sample_idx, first_err_idx, first_err_vld, halted
    );
endinterface

// File: rtl/dff_golden_model.sv
// Cycle-level flip-flop model: tracks the expected Q and whether it can be trusted.
module dff_golden_model
    import dff_chk_pkg::*;
(
    input  logic Clk,
    input  logic CLR_B,
    input  logic en_i,
    input  logic hold_i,
    input  logic d_i,
    input  logic pre_b_i,
    input  logic clr_b_i,
    output logic exp_q_o,
    output logic exp_vld_o,
    output logic forb_c_o
);

    logic exp_q_q, exp_q_d;
    logic exp_vld_q, exp_vld_d;

    assign forb_c_o = !pre_b_i && !clr_b_i;

    // A forbidden sample leaves the flip-flop state undefined, so the next edge is not trusted
    always_comb begin
        exp_q_d   = exp_q_q;
        exp_vld_d = exp_vld_q;
        if (!hold_i) begin
            if (en_i) begin
                exp_q_d   = exp_next(d_i, pre_b_i, clr_b_i);
                exp_vld_d = !forb_c_o;
            end else begin
                exp_vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge Clk or negedge CLR_B) begin
        if (!CLR_B) begin
            exp_q_q   <= 1'b0;
            exp_vld_q <= 1'b0;
        end else begin
            exp_q_q   <= exp_q_d;
            exp_vld_q <= exp_vld_d;
        end
    end

    assign exp_q_o   = exp_q_q;
    assign exp_vld_o = exp_vld_q;

endmodule

// File: rtl/dff_response_checker.sv
// Response checker for a D flip-flop with async preset/clear: FSM plus saturating counters.
module dff_response_checker
    import dff_chk_pkg::*;
#(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned IDX_W       = 16,
    parameter bit          STOP_ON_ERR = 1'b0
) (
    input  logic                  Clk,
    input  logic                  CLR_B,
    dff_response_checker_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [IDX_W-1:0] IDX_MAX = {IDX_W{1'b1}};

    chk_state_e       state_q, state_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] forb_cnt_q, forb_cnt_d;
    logic [IDX_W-1:0] sample_idx_q, sample_idx_d;
    logic [IDX_W-1:0] first_err_idx_q, first_err_idx_d;
    logic             first_err_vld_q, first_err_vld_d;
    logic             halted_q, halted_d;

    obs_t obs_c;
    logic hold_c, exp_q, exp_vld, forb_c, expected_c, mismatch_c;

    assign obs_c = '{d: bus.D_obs, pre_b: bus.PRE_B_obs, clr_b: bus.CLR_B_obs,
                     q: bus.Q_obs, qb: bus.Qb_obs};
    assign hold_c = (state_q == HALT);

    dff_golden_model u_model (
        .Clk       (Clk),
        .CLR_B     (CLR_B),
        .en_i      (bus.en),
        .hold_i    (hold_c),
        .d_i       (obs_c.d),
        .pre_b_i   (obs_c.pre_b),
        .clr_b_i   (obs_c.clr_b),
        .exp_q_o   (exp_q),
        .exp_vld_o (exp_vld),
        .forb_c_o  (forb_c)
    );

    assign expected_c = exp_now(exp_q, obs_c.pre_b, obs_c.clr_b);
    assign mismatch_c = (obs_c.q != expected_c) || (obs_c.qb == obs_c.q);

    // Next state and counter updates; err is a pulse, so it defaults low every edge
    always_comb begin
        state_d         = state_q;
        err_d           = 1'b0;
        err_cnt_d       = err_cnt_q;
        forb_cnt_d      = forb_cnt_q;
        sample_idx_d    = sample_idx_q;
        first_err_idx_d = first_err_idx_q;
        first_err_vld_d = first_err_vld_q;
        halted_d        = halted_q;

        if (state_q != HALT && bus.en && forb_c && forb_cnt_q != CNT_MAX) begin
            forb_cnt_d = forb_cnt_q + CNT_W'(1);
        end

        case (state_q)
            WARMUP: begin
                if (bus.en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!bus.en) begin
                    state_d = WARMUP;
                end else if (exp_vld && !forb_c) begin
                    if (sample_idx_q != IDX_MAX) begin
                        sample_idx_d = sample_idx_q + IDX_W'(1);
                    end
                    if (mismatch_c) begin
                        err_d = 1'b1;
                        if (err_cnt_q != CNT_MAX) begin
                            err_cnt_d = err_cnt_q + CNT_W'(1);
                        end
                        if (!first_err_vld_q) begin
                            first_err_idx_d = sample_idx_q;
                            first_err_vld_d = 1'b1;
                        end
                        if (STOP_ON_ERR) begin
                            state_d  = HALT;
                            halted_d = 1'b1;
                        end
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = WARMUP;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge CLR_B) begin
        if (!CLR_B) begin
            state_q         <= WARMUP;
            err_q           <= 1'b0;
            err_cnt_q       <= '0;
            forb_cnt_q      <= '0;
            sample_idx_q    <= '0;
            first_err_idx_q <= '0;
            first_err_vld_q <= 1'b0;
            halted_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            err_q           <= err_d;
            err_cnt_q       <= err_cnt_d;
            forb_cnt_q      <= forb_cnt_d;
            sample_idx_q    <= sample_idx_d;
            first_err_idx_q <= first_err_idx_d;
            first_err_vld_q <= first_err_vld_d;
            halted_q        <= halted_d;
        end
    end

    assign bus.err           = err_q;
    assign bus.err_cnt       = err_cnt_q;
    assign bus.forb_cnt      = forb_cnt_q;
    assign bus.sample_idx    = sample_idx_q;
    assign bus.first_err_idx = first_err_idx_q;
    assign bus.first_err_vld = first_err_vld_q;
    assign bus.halted        = halted_q;

endmodule
